// File: rtl/timer_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | timer_ctrl_pkg : shared state and mode encodings for timer_ctrl |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
package timer_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage
`default_nettype wire

// File: rtl/timer_ctrl_counter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | timer_ctrl_counter : free-running up counter, async + sync clear |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
module timer_ctrl_counter #(
  parameter int BW = 8
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          clr_i,
  output logic [BW-1:0] count_o
);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      count_o <= '0;
    end else if (clr_i) begin
      count_o <= '0;
    end else begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/timer_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | timer_ctrl : one-shot / periodic interval timer around a counter |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int BW  = 8,
  parameter int TCW = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           cfg_valid_i,
  output logic           cfg_ready_o,
  input  logic [BW-1:0]  cfg_period_i,
  input  logic           cfg_mode_i,
  input  logic           start_i,
  input  logic           stop_i,
  output logic           busy_o,
  output logic           tick_o,
  output logic           done_o,
  output logic [BW-1:0]  count_o,
  output logic [TCW-1:0] tick_cnt_o
);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [BW-1:0] r_period;
  logic          r_mode;
  logic          w_run;
  logic          w_match;
  logic          w_cfg_fire;
  logic          w_start;
  logic          w_stop_run;
  logic          w_tick;
  logic          w_clr;

  assign w_run       = (r_state == ST_RUN);
  assign cfg_ready_o = !w_run;
  assign w_match     = w_run && (count_o == r_period);
  assign w_cfg_fire  = cfg_valid_i && cfg_ready_o;
  assign w_start     = (r_state == ST_ARMED) && start_i && !stop_i;
  assign w_stop_run  = w_run && stop_i;
  // A stop in the same cycle as a match suppresses the tick.
  assign w_tick      = w_match && !stop_i;
  assign w_clr       = rst_i || !w_run || w_match || w_stop_run;

  timer_ctrl_counter #(
    .BW (BW)
  ) u_counter (
    .clk_i   (clk_i),
    .arst_i  (1'b0),
    .clr_i   (w_clr),
    .count_o (count_o)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_cfg_fire) w_state_nxt = ST_ARMED;
      ST_ARMED: if (w_start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (stop_i) begin
          w_state_nxt = ST_ARMED;
        end else if (w_match && (r_mode == MODE_ONESHOT)) begin
          w_state_nxt = ST_ARMED;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_period   <= '0;
      r_mode     <= MODE_ONESHOT;
      tick_o     <= 1'b0;
      done_o     <= 1'b0;
      busy_o     <= 1'b0;
      tick_cnt_o <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Config lands on the same edge as a start, so it governs that run.
      if (w_cfg_fire) begin
        r_period <= cfg_period_i;
        r_mode   <= cfg_mode_i;
      end
      tick_o <= w_tick;
      done_o <= w_tick && (r_mode == MODE_ONESHOT);
      busy_o <= (w_state_nxt == ST_RUN);
      if (w_start) begin
        tick_cnt_o <= '0;
      end else if (w_tick) begin
        tick_cnt_o <= tick_cnt_o + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_timer_ctrl : directed self-checking bench for timer_ctrl      |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
module tb_timer_ctrl;

  localparam int BW  = 8;
  localparam int TCW = 16;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           cfg_valid_i;
  logic           cfg_ready_o;
  logic [BW-1:0]  cfg_period_i;
  logic           cfg_mode_i;
  logic           start_i;
  logic           stop_i;
  logic           busy_o;
  logic           tick_o;
  logic           done_o;
  logic [BW-1:0]  count_o;
  logic [TCW-1:0] tick_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  timer_ctrl #(
    .BW  (BW),
    .TCW (TCW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_period_i (cfg_period_i),
    .cfg_mode_i   (cfg_mode_i),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .busy_o       (busy_o),
    .tick_o       (tick_o),
    .done_o       (done_o),
    .count_o      (count_o),
    .tick_cnt_o   (tick_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past one rising edge; outputs are then stable for sampling.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_cfg(input int period, input logic mode);
    cfg_valid_i  = 1'b1;
    cfg_period_i = BW'(period);
    cfg_mode_i   = mode;
    step();
    cfg_valid_i  = 1'b0;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic do_stop();
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; cfg_valid_i = 1'b0; cfg_period_i = '0; cfg_mode_i = 1'b0;
    start_i = 1'b0; stop_i = 1'b0;

    // 1. Reset state and start without config
    step(); step();
    check("rst_busy",    32'(busy_o), 0);
    check("rst_ready",   32'(cfg_ready_o), 1);
    check("rst_count",   32'(count_o), 0);
    check("rst_tick",    32'(tick_o), 0);
    check("rst_tickcnt", 32'(tick_cnt_o), 0);
    rst_i = 1'b0;
    do_start();
    check("idle_start_busy",  32'(busy_o), 0);
    check("idle_start_count", 32'(count_o), 0);
    step();
    check("idle_start_count2", 32'(count_o), 0);

    // 2. P=3 periodic
    do_cfg(3, 1'b1);
    do_start();
    check("per_k_busy",  32'(busy_o), 1);
    check("per_k_count", 32'(count_o), 0);
    check("per_k_ready", 32'(cfg_ready_o), 0);
    for (int i = 1; i <= 12; i++) begin
      step();
      check("per_count",   32'(count_o), 32'(i % 4));
      check("per_tick",    32'(tick_o), (i % 4 == 0) ? 1 : 0);
      check("per_tickcnt", 32'(tick_cnt_o), 32'(i / 4));
      check("per_busy",    32'(busy_o), 1);
      check("per_done",    32'(done_o), 0);
    end
    do_stop();
    check("per_stop_busy", 32'(busy_o), 0);

    // 3. P=5 one-shot
    do_cfg(5, 1'b0);
    do_start();
    for (int i = 1; i <= 6; i++) begin
      step();
      check("os_tick",  32'(tick_o), (i == 6) ? 1 : 0);
      check("os_done",  32'(done_o), (i == 6) ? 1 : 0);
      check("os_busy",  32'(busy_o), (i < 6) ? 1 : 0);
      check("os_count", 32'(count_o), (i < 6) ? 32'(i) : 0);
      check("os_ready", 32'(cfg_ready_o), (i == 6) ? 1 : 0);
    end
    step();
    check("os_after_tick",  32'(tick_o), 0);
    check("os_after_done",  32'(done_o), 0);
    check("os_after_count", 32'(count_o), 0);

    // 4. Stop mid-count, restart, stop coincident with match
    do_cfg(3, 1'b1);
    do_start();
    step();
    step();
    check("stp_pre_count", 32'(count_o), 2);
    do_stop();
    check("stp_busy",  32'(busy_o), 0);
    check("stp_tick",  32'(tick_o), 0);
    check("stp_count", 32'(count_o), 0);
    step();
    check("stp_hold_count", 32'(count_o), 0);
    do_start();
    check("rst_tickcnt_clear", 32'(tick_cnt_o), 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("restart_tick", 32'(tick_o), (i == 4) ? 1 : 0);
    end
    check("restart_tickcnt", 32'(tick_cnt_o), 1);
    step(); step(); step();
    check("match_count", 32'(count_o), 3);
    do_stop();
    check("stopmatch_tick",    32'(tick_o), 0);
    check("stopmatch_busy",    32'(busy_o), 0);
    check("stopmatch_tickcnt", 32'(tick_cnt_o), 1);
    start_i = 1'b1; stop_i = 1'b1;
    step();
    start_i = 1'b0; stop_i = 1'b0;
    check("stop_prio_busy", 32'(busy_o), 0);

    // 5a. P=0 periodic
    do_cfg(0, 1'b1);
    do_start();
    check("p0_k_tick", 32'(tick_o), 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("p0_tick",    32'(tick_o), 1);
      check("p0_tickcnt", 32'(tick_cnt_o), 32'(i));
      check("p0_count",   32'(count_o), 0);
    end
    do_stop();

    // 5b. P=255 one-shot: no wrap before the tick
    do_cfg(255, 1'b0);
    do_start();
    for (int i = 1; i <= 255; i++) begin
      step();
      check("p255_tick", 32'(tick_o), 0);
    end
    check("p255_count", 32'(count_o), 255);
    step();
    check("p255_tick_end",  32'(tick_o), 1);
    check("p255_done_end",  32'(done_o), 1);
    check("p255_count_end", 32'(count_o), 0);

    // 5c. cfg during RUN is ignored
    do_cfg(3, 1'b1);
    do_start();
    cfg_valid_i = 1'b1; cfg_period_i = 8'd9; cfg_mode_i = 1'b0;
    #1;
    check("run_cfg_ready", 32'(cfg_ready_o), 0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check("run_cfg_tick", 32'(tick_o), (i % 4 == 0) ? 1 : 0);
      check("run_cfg_busy", 32'(busy_o), 1);
    end
    cfg_valid_i = 1'b0;
    do_stop();

    // 6. Reset mid-RUN, then cfg+start in the same cycle
    do_cfg(7, 1'b1);
    do_start();
    step(); step();
    check("mid_pre_count", 32'(count_o), 2);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("mid_busy",  32'(busy_o), 0);
    check("mid_count", 32'(count_o), 0);
    check("mid_tick",  32'(tick_o), 0);
    check("mid_done",  32'(done_o), 0);
    check("mid_ready", 32'(cfg_ready_o), 1);
    do_start();
    check("mid_nocfg_busy", 32'(busy_o), 0);
    do_cfg(7, 1'b1);
    cfg_valid_i = 1'b1; cfg_period_i = 8'd1; cfg_mode_i = 1'b1; start_i = 1'b1;
    step();
    cfg_valid_i = 1'b0; start_i = 1'b0;
    check("same_busy", 32'(busy_o), 1);
    step();
    check("same_tick1", 32'(tick_o), 0);
    check("same_count", 32'(count_o), 1);
    step();
    check("same_tick2", 32'(tick_o), 1);
    step();
    check("same_tick3", 32'(tick_o), 0);
    step();
    check("same_tick4", 32'(tick_o), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
